// File: rtl/imem_loader.sv
// Byte-stream loader for the 16-bit instruction memory; holds the CPU in reset while loading.
// Optional checksum byte after the data is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_HI, S_LO, S_CHK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_HI, S_LO, S_DONE} state_t;
`endif

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last_idx;
  logic [7:0]        hi_byte;
  logic              take;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign take = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_hold <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      idx      <= '0;
      last_idx <= '0;
      hi_byte  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start) begin
            state    <= S_COUNT;
            err      <= 1'b0;
            idx      <= '0;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        S_COUNT: begin
          if (take) begin
            if (in_data == 8'd0 || 32'(in_data) > DEPTH) begin
              err      <= 1'b1;
              in_ready <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              // Store N-1 so the last-word test is a plain index compare.
              last_idx <= ADDR_W'(in_data - 8'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum     <= in_data;
`endif
              state    <= S_HI;
            end
          end
        end
        S_HI: begin
          if (take) begin
            hi_byte <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum    <= csum ^ in_data;
`endif
            state   <= S_LO;
          end
        end
        S_LO: begin
          if (take) begin
            wr_en   <= 1'b1;
            wr_addr <= idx;
            wr_data <= {hi_byte, in_data};
            idx     <= idx + ADDR_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum    <= csum ^ in_data;
`endif
            if (idx == last_idx) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= S_CHK;
`else
              in_ready <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
`endif
            end else begin
              state <= S_HI;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (take) begin
            if (in_data != csum) err <= 1'b1;
            in_ready <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a byte-count based reference model.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, wr_en, cpu_hold, busy, done, err;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;

  int checks = 0;
  int errors = 0;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  // Instruction memory driven by the DUT write port.
  logic [15:0] dmem [16];
  int dut_wr = 0;
  always @(posedge clk) begin
    if (wr_en) begin
      dmem[wr_addr] <= wr_data;
      dut_wr <= dut_wr + 1;
    end
  end

  // Reference model: tracks how many bytes of the current load were accepted.
  bit          m_act = 0, m_fin = 0;
  int          m_k = 0, m_n = 0;
  logic [7:0]  m_hi = 0, m_x = 0, m_b;
  logic        e_wr_en = 0, e_err = 0;
  logic [3:0]  e_addr = 0;
  logic [15:0] e_data = 0;
  logic [15:0] mmem [16];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 0; m_fin = 0; e_wr_en = 0; e_err = 0; e_addr = 0; e_data = 0;
    end else begin
      e_wr_en = 0;
      if (m_fin) begin
        m_act = 0; m_fin = 0;
      end else if (!m_act) begin
        if (load_start) begin m_act = 1; m_k = 0; e_err = 0; end
      end else if (in_valid) begin
        m_b = in_data;
        if (m_k == 0) begin
          if (m_b == 0 || m_b > 16) begin e_err = 1; m_fin = 1; end
          else begin m_n = m_b; m_x = m_b; end
        end else if (m_k <= 2 * m_n) begin
          m_x = m_x ^ m_b;
          if (m_k % 2 == 1) m_hi = m_b;
          else begin
            e_wr_en = 1;
            e_addr = 4'(m_k / 2 - 1);
            e_data = {m_hi, m_b};
            mmem[e_addr] = e_data;
            if (m_k == 2 * m_n && !CSUM) m_fin = 1;
          end
        end else begin
          if (m_b != m_x) e_err = 1;
          m_fin = 1;
        end
        m_k++;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    check("in_ready", 16'(in_ready), 16'(m_act && !m_fin));
    check("busy",     16'(busy),     16'(m_act));
    check("cpu_hold", 16'(cpu_hold), 16'(m_act));
    check("done",     16'(done),     16'(m_fin));
    check("err",      16'(err),      16'(e_err));
    check("wr_en",    16'(wr_en),    16'(e_wr_en));
    check("wr_addr",  16'(wr_addr),  16'(e_addr));
    check("wr_data",  wr_data,       e_data);
  end

  task automatic start_load();
    in_valid = 1'b1; in_data = 8'($urandom);   // ignored: not ready in IDLE
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit stray);
    int t;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0; in_data = 8'($urandom); @(negedge clk);
    end
    in_valid = 1'b1; in_data = b; load_start = stray;
    t = 0;
    while (!in_ready && t < 40) begin @(negedge clk); load_start = 1'b0; t++; end
    if (t >= 40) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
    end
    @(negedge clk);
    load_start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin
      in_valid = 1'b1; in_data = 8'($urandom);   // ignored in DONE/IDLE
      @(negedge clk); t++;
    end
    in_valid = 1'b0;
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%b, required 0", busy);
    end
  endtask

  logic [15:0] words [16];

  function automatic int pick_gap(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  task automatic do_load(input logic [7:0] cnt, input int gmode, input bit bad_csum, input bit stray);
    logic [7:0] x;
    start_load();
    x = cnt;
    send_byte(cnt, pick_gap(gmode), stray);
    if (cnt != 0 && cnt <= 16) begin
      for (int i = 0; i < int'(cnt); i++) begin
        send_byte(words[i][15:8], pick_gap(gmode), stray);
        send_byte(words[i][7:0],  pick_gap(gmode), stray);
        x = x ^ words[i][15:8] ^ words[i][7:0];
      end
      if (CSUM) send_byte(bad_csum ? ~x : x, pick_gap(gmode), stray);
    end
    wait_idle();
  endtask

  task automatic cmp_mem(input string name);
    for (int i = 0; i < 16; i++) check(name, dmem[i], mmem[i]);
  endtask

  initial begin
    int w0;
    logic [7:0] c;
    for (int i = 0; i < 16; i++) begin dmem[i] = 16'h0; mmem[i] = 16'h0; end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Six words, full throughput.
    words[0] = 16'h8180; words[1] = 16'h2CB2; words[2] = 16'hDC67;
    words[3] = 16'hDDD9; words[4] = 16'hFDB1; words[5] = 16'hC07B;
    w0 = dut_wr;
    do_load(8'd6, 0, 1'b0, 1'b0);
    check("t1_writes", 16'(dut_wr - w0), 16'd6);
    check("t1_err", 16'(err), 16'd0);
    check("t1_m0", dmem[0], 16'h8180); check("t1_m2", dmem[2], 16'hDC67);
    check("t1_m5", dmem[5], 16'hC07B);

    // Invalid counts.
    w0 = dut_wr;
    do_load(8'h00, 0, 1'b0, 1'b0);
    check("t2_err0", 16'(err), 16'd1);
    do_load(8'h11, 0, 1'b0, 1'b0);
    check("t2_err17", 16'(err), 16'd1);
    check("t2_writes", 16'(dut_wr - w0), 16'd0);

    // Next load_start clears err; two words with in_valid every other cycle.
    words[0] = 16'h1234; words[1] = 16'hABCD;
    start_load();
    check("t3_errclr", 16'(err), 16'd0);
    send_byte(8'd2, 1, 1'b0);
    send_byte(8'h12, 1, 1'b0); send_byte(8'h34, 1, 1'b0);
    send_byte(8'hAB, 1, 1'b0); send_byte(8'hCD, 1, 1'b0);
    if (CSUM) send_byte(8'h02 ^ 8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD, 1, 1'b0);
    wait_idle();
    check("t3_m0", dmem[0], 16'h1234); check("t3_m1", dmem[1], 16'hABCD);

    // Reset after the third word of a six-word load.
    start_load();
    send_byte(8'd6, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0); send_byte(8'h22, 0, 1'b0);
    send_byte(8'h33, 0, 1'b0); send_byte(8'h44, 0, 1'b0);
    send_byte(8'h55, 0, 1'b0); send_byte(8'h66, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t4_rst_out", {7'd0, in_ready, wr_en, cpu_hold, busy, done, err, 3'd0}, 16'h0);
    check("t4_rst_addr", 16'(wr_addr), 16'h0);
    check("t4_rst_data", wr_data, 16'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t4_m0", dmem[0], 16'h1122); check("t4_m2", dmem[2], 16'h5566);
    check("t4_m3", dmem[3], 16'hDDD9); check("t4_m5", dmem[5], 16'hC07B);
    words[0] = 16'h0F0F; words[1] = 16'hF00F; words[2] = 16'h7E57;
    do_load(8'd3, 2, 1'b0, 1'b0);
    check("t4_after", dmem[2], 16'h7E57);

`ifdef IMEM_LOADER_CHECKSUM_EN
    start_load();
    send_byte(8'h01, 0, 1'b0); send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h5A, 0, 1'b0); send_byte(8'hFE, 0, 1'b0);
    wait_idle();
    check("t5_good_err", 16'(err), 16'd0);
    start_load();
    send_byte(8'h01, 0, 1'b0); send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h5A, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
    wait_idle();
    check("t5_bad_word", dmem[0], 16'hA55A);
    check("t5_bad_err", 16'(err), 16'd1);
`endif

    // load_start pulsed on every byte of a load.
    for (int i = 0; i < 16; i++) words[i] = 16'($urandom);
    do_load(8'd4, 2, 1'b0, 1'b1);
    cmp_mem("t6_mem");

    // Randomized loads.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 16; i++) words[i] = 16'($urandom);
      case ($urandom_range(0, 9))
        0: c = 8'h00;
        1: c = 8'($urandom_range(17, 255));
        default: c = 8'($urandom_range(1, 16));
      endcase
      do_load(c, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    cmp_mem("final_mem");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
